mem_line_server: RTL and testbench

Backing-memory responder that serves cache-line fill and write-back requests from the instruction and data caches. It owns the main memory array, arbitrates between the two cache request channels, models a fixed access latency, and returns one full line per transaction. It sits below `fetch` and `dcache`. Each cache asserts a request and stalls on it, the way the fetch stage holds `f_wait_for_cache`, until this block acknowledges.

---
 rtl/mem_line_server.sv | 189 ++++++++++++++++++
 tb/tb_mem_line_server.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_server.sv
// -----------------------------------------------------------------------------
// mem_line_server
//
// Backing-memory responder below the instruction and data caches. It owns the
// main line array and arbitrates between the icache (read-only) and dcache
// (fill or write-back) request channels. It serves one full line per
// transaction after a fixed access latency.
//
// Transaction flow: IDLE accepts one request -> BUSY counts LATENCY-1 down to
// zero -> the array access happens on the zero edge -> RESP strobes the ack
// for one cycle -> IDLE.
//
// Ports:
//   clk_i        system clock, rising-edge active
//   rst_i        asynchronous active-high reset
//   ic_req_i     icache line-read request, held until ic_ack_o
//   ic_addr_i    icache byte address
//   ic_ack_o     one-cycle response strobe to icache
//   ic_data_o    returned line, valid while ic_ack_o is high, held otherwise
//   dc_req_i     dcache request, held until dc_ack_o
//   dc_we_i      1 = line write-back, 0 = line fill
//   dc_addr_i    dcache byte address
//   dc_wdata_i   write-back line
//   dc_ack_o     one-cycle response strobe to dcache
//   dc_rdata_o   fill line; on write-back it echoes the written line
//
// INIT_FILE names an optional hex image for preloading the array.
// -----------------------------------------------------------------------------
module mem_line_server #(
    parameter int    LINE_BITS   = 128,
    parameter int    ADDR_BITS   = 20,
    parameter int    DEPTH_LINES = 1024,
    parameter int    LATENCY     = 5,
    parameter string INIT_FILE   = ""
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ic_req_i,
    input  logic [ADDR_BITS-1:0] ic_addr_i,
    output logic                 ic_ack_o,
    output logic [LINE_BITS-1:0] ic_data_o,
    input  logic                 dc_req_i,
    input  logic                 dc_we_i,
    input  logic [ADDR_BITS-1:0] dc_addr_i,
    input  logic [LINE_BITS-1:0] dc_wdata_i,
    output logic                 dc_ack_o,
    output logic [LINE_BITS-1:0] dc_rdata_o
);

    localparam int IDX_BITS = $clog2(DEPTH_LINES);
    // LATENCY-1 is the largest value the counter ever holds.
    localparam int CNT_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  sel_dc_q, sel_dc_d;    // granted channel: 1 = dcache
    logic                  last_dc_q, last_dc_d;  // last grant: 1 = dcache
    logic [IDX_BITS-1:0]   idx_q, idx_d;
    logic                  we_q, we_d;
    logic [LINE_BITS-1:0]  wdata_q, wdata_d;
    logic                  ic_ack_q, ic_ack_d;
    logic                  dc_ack_q, dc_ack_d;
    logic [LINE_BITS-1:0]  ic_data_q, ic_data_d;
    logic [LINE_BITS-1:0]  dc_rdata_q, dc_rdata_d;

    logic [LINE_BITS-1:0]  mem [DEPTH_LINES];
    logic [LINE_BITS-1:0]  mem_rdata;
    logic                  mem_we;
    logic                  access;
    logic                  grant_dc;
    logic [IDX_BITS-1:0]   ic_idx;
    logic [IDX_BITS-1:0]   dc_idx;

    // Bits [3:0] select a byte within the line; index bits above the array
    // depth are dropped so out-of-range lines wrap.
    assign ic_idx = ic_addr_i[IDX_BITS+3:4];
    assign dc_idx = dc_addr_i[IDX_BITS+3:4];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{ic_addr_i, dc_addr_i};

    // dcache wins when it is alone, or on a tie when icache was granted last.
    assign grant_dc = dc_req_i && (!ic_req_i || !last_dc_q);

    assign access    = (state_q == S_BUSY) && (cnt_q == '0);
    assign mem_we    = access && we_q;
    assign mem_rdata = mem[idx_q];

    // NOTE: every signal gets its default before the case statement so no
    // path through this block can leave a value unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_dc_d   = sel_dc_q;
        last_dc_d  = last_dc_q;
        idx_d      = idx_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        ic_ack_d   = 1'b0;
        dc_ack_d   = 1'b0;
        ic_data_d  = ic_data_q;
        dc_rdata_d = dc_rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (ic_req_i || dc_req_i) begin
                    sel_dc_d  = grant_dc;
                    last_dc_d = grant_dc;
                    idx_d     = grant_dc ? dc_idx : ic_idx;
                    we_d      = grant_dc && dc_we_i;
                    wdata_d   = dc_wdata_i;
                    cnt_d     = CNT_BITS'(LATENCY - 1);
                    state_d   = S_BUSY;
                end
            end

            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    if (sel_dc_q) begin
                        dc_ack_d   = 1'b1;
                        dc_rdata_d = we_q ? wdata_q : mem_rdata;
                    end else begin
                        ic_ack_d  = 1'b1;
                        ic_data_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_BITS'(1);
                end
            end

            // The ack registers are high for this one cycle only; requests
            // are not sampled here.
            S_RESP: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sel_dc_q   <= 1'b0;
            last_dc_q  <= 1'b0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            ic_ack_q   <= 1'b0;
            dc_ack_q   <= 1'b0;
            ic_data_q  <= '0;
            dc_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_dc_q   <= sel_dc_d;
            last_dc_q  <= last_dc_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            ic_ack_q   <= ic_ack_d;
            dc_ack_q   <= dc_ack_d;
            ic_data_q  <= ic_data_d;
            dc_rdata_q <= dc_rdata_d;
        end
    end

    // NOTE: the array has no reset; contents survive reset, and an aborted
    // write never reaches here because reset forces the FSM out of BUSY.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign ic_ack_o   = ic_ack_q;
    assign dc_ack_o   = dc_ack_q;
    assign ic_data_o  = ic_data_q;
    assign dc_rdata_o = dc_rdata_q;

endmodule

// File: tb/tb_mem_line_server.sv
// -----------------------------------------------------------------------------
// tb_mem_line_server
//
// Directed testbench for mem_line_server. Driver tasks raise requests and push
// the expected response (ack cycle and line) onto a per-channel queue; a
// monitor samples on the falling edge and pops/compares whenever an ack shows.
// -----------------------------------------------------------------------------
module tb_mem_line_server;

    localparam int LAT = 5;
    localparam int LB  = 128;
    localparam int AB  = 20;

    localparam logic [LB-1:0] LINE1 = 128'h00000004_00000003_00000002_00000001;
    localparam logic [LB-1:0] DB    = 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF;
    localparam logic [LB-1:0] WR    = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    localparam logic [LB-1:0] OLD   = 128'h11111111_22222222_33333333_44444444;
    localparam logic [LB-1:0] NEW   = 128'hBBBBBBBB_AAAAAAAA_99999999_88888888;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ic_req = 1'b0;
    logic [AB-1:0] ic_addr = '0;
    logic          ic_ack;
    logic [LB-1:0] ic_data;
    logic          dc_req = 1'b0;
    logic          dc_we = 1'b0;
    logic [AB-1:0] dc_addr = '0;
    logic [LB-1:0] dc_wdata = '0;
    logic          dc_ack;
    logic [LB-1:0] dc_rdata;

    typedef struct {
        int            at_cyc;
        logic [LB-1:0] data;
    } exp_t;

    exp_t ic_q[$];
    exp_t dc_q[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_miss = 0;

    mem_line_server #(
        .LINE_BITS  (LB),
        .ADDR_BITS  (AB),
        .DEPTH_LINES(1024),
        .LATENCY    (LAT),
        .INIT_FILE  ("")
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .ic_req_i  (ic_req),
        .ic_addr_i (ic_addr),
        .ic_ack_o  (ic_ack),
        .ic_data_o (ic_data),
        .dc_req_i  (dc_req),
        .dc_we_i   (dc_we),
        .dc_addr_i (dc_addr),
        .dc_wdata_i(dc_wdata),
        .dc_ack_o  (dc_ack),
        .dc_rdata_o(dc_rdata)
    );

    always #5 clk = ~clk;

    // Cycle k starts at the rising edge that sets cyc to k.
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [LB-1:0] act,
                         input logic [LB-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            check("reset ic_ack",   {127'd0, ic_ack}, '0);
            check("reset dc_ack",   {127'd0, dc_ack}, '0);
            check("reset ic_data",  ic_data,  '0);
            check("reset dc_rdata", dc_rdata, '0);
        end else begin
            if (ic_ack) begin
                if (ic_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL ic_ack unexpected @cycle %0d: got ack, want none", cyc);
                end else begin
                    e = ic_q.pop_front();
                    check("ic_ack cycle", LB'(cyc), LB'(e.at_cyc));
                    check("ic_data", ic_data, e.data);
                end
            end
            if (dc_ack) begin
                if (dc_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL dc_ack unexpected @cycle %0d: got ack, want none", cyc);
                end else begin
                    e = dc_q.pop_front();
                    check("dc_ack cycle", LB'(cyc), LB'(e.at_cyc));
                    check("dc_rdata", dc_rdata, e.data);
                end
            end
        end
    end

    // ---------------- driver tasks (called #1 after a rising edge) --------
    // extra = cycles spent waiting behind another channel's transaction.
    task automatic issue_ic(input logic [AB-1:0] addr, input logic [LB-1:0] exp,
                            input int extra);
        ic_req  = 1'b1;
        ic_addr = addr;
        ic_q.push_back('{at_cyc: cyc + LAT + 1 + extra, data: exp});
    endtask

    task automatic issue_dc(input logic we, input logic [AB-1:0] addr,
                            input logic [LB-1:0] wdata, input logic [LB-1:0] exp,
                            input int extra);
        dc_req   = 1'b1;
        dc_we    = we;
        dc_addr  = addr;
        dc_wdata = wdata;
        dc_q.push_back('{at_cyc: cyc + LAT + 1 + extra, data: exp});
    endtask

    // Waits for the channel's ack, then returns #1 into the following cycle.
    task automatic wait_ack(input logic dc);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = dc ? dc_ack : ic_ack;
        end
        if (!got) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s ack timeout @cycle %0d: got no ack, want ack",
                     dc ? "dc" : "ic", cyc);
        end
        @(posedge clk);
        #1;
    endtask

    // Single transaction; address and data are scrambled after acceptance.
    task automatic dc_txn(input logic we, input logic [AB-1:0] addr,
                          input logic [LB-1:0] wdata, input logic [LB-1:0] exp);
        issue_dc(we, addr, wdata, exp, 0);
        @(posedge clk);
        #1;
        dc_addr  = ~addr;
        dc_wdata = ~wdata;
        wait_ack(1'b1);
        dc_req = 1'b0;
    endtask

    task automatic ic_txn(input logic [AB-1:0] addr, input logic [LB-1:0] exp);
        issue_ic(addr, exp, 0);
        @(posedge clk);
        #1;
        ic_addr = ~addr;
        wait_ack(1'b0);
        ic_req = 1'b0;
    endtask

    task automatic pulse_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1;
        pulse_reset(3);

        // Basic fill: load line 1, then icache reads it back.
        dc_txn(1'b1, 20'h00010, LINE1, LINE1);
        ic_txn(20'h00010, LINE1);

        // Write then read: write-back echo, then fill returns the same line.
        dc_txn(1'b1, 20'h00020, DB, DB);
        dc_txn(1'b0, 20'h00020, '0, DB);

        // Contention after reset: dcache wins the first tie (ack at +6),
        // dcache re-requests immediately so the next tie goes to icache
        // (ack at +13), then dcache alone (ack at +20).
        pulse_reset(2);
        issue_ic(20'h00010, LINE1, LAT + 2);
        issue_dc(1'b0, 20'h00020, '0, DB, 0);
        wait_ack(1'b1);
        issue_dc(1'b0, 20'h00010, '0, LINE1, LAT + 2);
        wait_ack(1'b0);
        ic_req = 1'b0;
        wait_ack(1'b1);
        // Last grant was dcache, so this tie goes to icache first.
        issue_ic(20'h00020, DB, 0);
        issue_dc(1'b0, 20'h00020, '0, DB, LAT + 2);
        wait_ack(1'b0);
        ic_req = 1'b0;
        wait_ack(1'b1);
        dc_req = 1'b0;

        // Wrap: index 1024+3 aliases index 3; low byte bits are ignored.
        dc_txn(1'b1, 20'h04030, WR, WR);
        dc_txn(1'b0, 20'h00035, '0, WR);
        ic_txn(20'h00030, WR);

        // Reset mid-access: the write of NEW is aborted at counter = 2.
        dc_txn(1'b1, 20'h00040, OLD, OLD);
        dc_req   = 1'b1;
        dc_we    = 1'b1;
        dc_addr  = 20'h00040;
        dc_wdata = NEW;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b1;
        dc_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        dc_txn(1'b0, 20'h00040, '0, OLD);

        // Held request: second transaction acked 7 cycles after the first.
        issue_ic(20'h00030, WR, 0);
        issue_ic(20'h00030, WR, LAT + 2);
        wait_ack(1'b0);
        wait_ack(1'b0);
        ic_req = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check("ic responses outstanding", LB'(ic_q.size()), '0);
        check("dc responses outstanding", LB'(dc_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
